// File: rtl/count12_seq_ctrl.sv
// Sequencing controller for an external 4-bit count4 counter: load, run to a terminal value, wrap, count wraps.
// Optional freeze support is compiled in when COUNT12_SEQ_PAUSE_EN is defined.

module count12_seq_ctrl #(
  parameter logic [3:0] START_VAL = 4'd1,
  parameter logic [3:0] MAX_VAL   = 4'd12
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [3:0] limit,
  input  logic [7:0] cycles,
  input  logic [3:0] Q,
  output logic       c_enable,
  output logic       c_load,
  output logic [3:0] c_d,
  output logic       busy,
  output logic       tick,
  output logic       done,
  output logic [7:0] wraps
);

  // state | meaning
  // IDLE  | waiting for start, counter held
  // LOAD  | one cycle, counter loaded with START_VAL
  // RUN   | counting START_VAL..term, wrapping on term
  // PAUSE | counter frozen (COUNT12_SEQ_PAUSE_EN builds only)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
`ifdef COUNT12_SEQ_PAUSE_EN
  localparam logic [1:0] ST_PAUSE = 2'd3;
`endif

  logic [1:0] state_q, state_d;
  logic [3:0] term_q, term_d;
  logic [7:0] cyc_q, cyc_d;
  logic [7:0] wraps_q, wraps_d;
  logic       done_q, done_d;
  logic [7:0] wraps_inc;
  logic       pause_act;

`ifdef COUNT12_SEQ_PAUSE_EN
  assign pause_act = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_act    = 1'b0;
`endif

  assign wraps_inc = (wraps_q == 8'hFF) ? wraps_q : wraps_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    term_d   = term_q;
    cyc_d    = cyc_q;
    wraps_d  = wraps_q;
    done_d   = 1'b0;
    c_enable = 1'b0;
    c_load   = 1'b0;
    tick     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_LOAD;
          term_d  = (limit > START_VAL) ? limit : MAX_VAL;
          cyc_d   = cycles;
          wraps_d = 8'd0;
        end
      end

      ST_LOAD: begin
        c_load  = 1'b1;
        state_d = stop ? ST_IDLE : ST_RUN;
      end

      ST_RUN: begin
        // Q above term is recovered with a silent reload rather than a wrap.
        c_enable = 1'b1;
        c_load   = (Q >= term_q);
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pause_act) begin
`ifdef COUNT12_SEQ_PAUSE_EN
          c_enable = 1'b0;
          c_load   = 1'b0;
          state_d  = ST_PAUSE;
`endif
        end else if (Q == term_q) begin
          tick    = 1'b1;
          wraps_d = wraps_inc;
          if ((cyc_q != 8'd0) && (wraps_inc == cyc_q)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

`ifdef COUNT12_SEQ_PAUSE_EN
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      term_q  <= MAX_VAL;
      cyc_q   <= 8'd0;
      wraps_q <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      cyc_q   <= cyc_d;
      wraps_q <= wraps_d;
      done_q  <= done_d;
    end
  end

  assign c_d   = START_VAL;
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign wraps = wraps_q;

endmodule

// File: tb/tb_count12_seq_ctrl.sv
// Bench for count12_seq_ctrl with a behavioural count4 counter closing the loop on Q.
module tb_count12_seq_ctrl;

`ifdef COUNT12_SEQ_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif
  localparam int START = 1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [3:0] limit = 4'd0;
  logic [7:0] cycles = 8'd0;
  logic [3:0] q_m;
  logic       c_enable, c_load, busy, tick, done;
  logic [3:0] c_d;
  logic [7:0] wraps;
  logic       inj = 1'b0;
  logic [3:0] inj_val = 4'd0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  count12_seq_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .pause(pause),
    .limit(limit), .cycles(cycles), .Q(q_m),
    .c_enable(c_enable), .c_load(c_load), .c_d(c_d),
    .busy(busy), .tick(tick), .done(done), .wraps(wraps)
  );

  always @(posedge clk or negedge resetn) begin
    if (!resetn)       q_m <= 4'd0;
    else if (inj)      q_m <= inj_val;
    else if (c_load)   q_m <= c_d;
    else if (c_enable) q_m <= q_m + 4'd1;
  end

  typedef struct {
    logic [3:0] lim;
    logic [7:0] cyc;
    int         term;
    int         exp_wraps;
  } vec_t;

  typedef struct {
    bit chk_q;
    int q, busy, cl, ce, tk, dn;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input bit cq, input int q, input int b, input int cl,
                      input int ce, input int tk, input int dn);
    exp_t e;
    e.chk_q = cq; e.q = q; e.busy = b; e.cl = cl; e.ce = ce; e.tk = tk; e.dn = dn;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    int cyc_n = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      if (e.chk_q) check($sformatf("%s c%0d Q", tag, cyc_n), int'(q_m), e.q);
      check($sformatf("%s c%0d busy", tag, cyc_n), int'(busy), e.busy);
      check($sformatf("%s c%0d c_load", tag, cyc_n), int'(c_load), e.cl);
      check($sformatf("%s c%0d c_enable", tag, cyc_n), int'(c_enable), e.ce);
      check($sformatf("%s c%0d tick", tag, cyc_n), int'(tick), e.tk);
      check($sformatf("%s c%0d done", tag, cyc_n), int'(done), e.dn);
      start = 1'b0;
      cyc_n++;
    end
  endtask

  task automatic wait_q(input int t);
    int n = 0;
    while (int'(q_m) != t && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (int'(q_m) != t) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_q: got %0d expected %0d", q_m, t);
    end
  endtask

  task automatic kick(input logic [3:0] lim, input logic [7:0] cyc);
    @(negedge clk);
    limit = lim; cycles = cyc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{lim: 4'd5,  cyc: 8'd3, term: 5,  exp_wraps: 3};
    vecs[1] = '{lim: 4'd0,  cyc: 8'd2, term: 12, exp_wraps: 2};
    vecs[2] = '{lim: 4'd1,  cyc: 8'd1, term: 12, exp_wraps: 1};
    vecs[3] = '{lim: 4'd2,  cyc: 8'd4, term: 2,  exp_wraps: 4};
    vecs[4] = '{lim: 4'd15, cyc: 8'd1, term: 15, exp_wraps: 1};
    vecs[5] = '{lim: 4'd12, cyc: 8'd2, term: 12, exp_wraps: 2};

    // Reset values while reset is held
    #3;
    check("rst c_enable", int'(c_enable), 0);
    check("rst c_load", int'(c_load), 0);
    check("rst c_d", int'(c_d), START);
    check("rst busy", int'(busy), 0);
    check("rst tick", int'(tick), 0);
    check("rst done", int'(done), 0);
    check("rst wraps", int'(wraps), 0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      limit = vecs[i].lim; cycles = vecs[i].cyc; start = 1'b1;
      push(0, 0, 1, 1, 0, 0, 0);
      for (int w = 0; w < vecs[i].exp_wraps; w++)
        for (int v = START; v <= vecs[i].term; v++)
          push(1, v, 1, int'(v == vecs[i].term), 1, int'(v == vecs[i].term), 0);
      push(1, START, 0, 0, 0, 0, 1);
      push(1, START, 0, 0, 0, 0, 0);
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d wraps", i), int'(wraps), vecs[i].exp_wraps);
    end

    // start and stop together in IDLE
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start+stop busy", int'(busy), 0);
    @(negedge clk);
    check("start+stop busy2", int'(busy), 0);

    // start while busy ignored, then stop on the terminal cycle
    kick(4'd4, 8'd0);
    wait_q(2);
    limit = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_q(4);
    check("ign tick at term", int'(tick), 1);
    @(negedge clk);
    check("ign wrapped Q", int'(q_m), START);
    wait_q(4);
    stop = 1'b1;
    #1;
    check("stop@term tick", int'(tick), 0);
    @(negedge clk);
    stop = 1'b0;
    check("stop@term busy", int'(busy), 0);
    check("stop@term wraps", int'(wraps), 1);
    check("stop@term done", int'(done), 0);

    // Q above term reloads without a tick
    kick(4'd5, 8'd0);
    wait_q(2);
    inj = 1'b1; inj_val = 4'd9;
    @(negedge clk);
    inj = 1'b0;
    check("q>term Q", int'(q_m), 9);
    check("q>term c_load", int'(c_load), 1);
    check("q>term tick", int'(tick), 0);
    @(negedge clk);
    check("q>term reload Q", int'(q_m), START);
    check("q>term wraps", int'(wraps), 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("q>term stop busy", int'(busy), 0);

    // pause for 4 cycles at Q=6
    kick(4'd0, 8'd0);
    wait_q(6);
    pause = 1'b1;
    @(negedge clk);
    check("pause k+1 Q", int'(q_m), PAUSE_EN ? 6 : 7);
    repeat (3) @(negedge clk);
    pause = 1'b0;
    @(negedge clk);
    check("pause k+5 Q", int'(q_m), PAUSE_EN ? 6 : 11);
    @(negedge clk);
    check("pause k+6 Q", int'(q_m), PAUSE_EN ? 7 : 12);
    check("pause busy", int'(busy), 1);
    check("pause wraps", int'(wraps), 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // reset mid-run at Q=7, no done afterwards
    kick(4'd0, 8'd1);
    wait_q(7);
    resetn = 1'b0;
    #1;
    check("midrst busy", int'(busy), 0);
    check("midrst c_enable", int'(c_enable), 0);
    check("midrst c_load", int'(c_load), 0);
    check("midrst tick", int'(tick), 0);
    check("midrst done", int'(done), 0);
    check("midrst wraps", int'(wraps), 0);
    @(negedge clk);
    resetn = 1'b1;
    begin
      int seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (done || busy || tick) seen++;
      end
      check("post-rst pulses", seen, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
